// File: rtl/holdem_pkg.sv
// Shared constants and types for the two-player hold'em board enumerator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package holdem_pkg;

    localparam int DECK_SIZE     = 52;
    localparam int BOARD_CARDS   = 5;
    localparam int HOLE_CARDS    = 2;
    localparam int NUM_BOARDS_2P = 1712304;   // C(48,5)

    // Verdict returned by the hand evaluator for one board.
    typedef enum logic [1:0] {
        RES_P1  = 2'b00,
        RES_TIE = 2'b01,
        RES_P2  = 2'b10,
        RES_BAD = 2'b11
    } res_code_e;

    // Card index; wide enough for any deck of up to 63 cards.
    typedef logic [5:0] card_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/next_free_card.sv
// Finds the lowest card index >= from_idx that is not excluded.
// Latency: purely combinational.
// Backpressure: none.
// Ports: excl (excluded-card mask), from_idx (search start),
//        idx (result, 0 when not found), found (a free card exists).
module next_free_card
    import holdem_pkg::*;
#(
    parameter int DECK = DECK_SIZE
) (
    input  logic [DECK-1:0] excl,
    input  card_idx_t       from_idx,
    output card_idx_t       idx,
    output logic            found
);

    // Scanning from the top down lets the last hit be the lowest match.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DECK - 1; i >= 0; i--) begin
            if (!excl[i] && (i >= int'(from_idx))) begin
                idx   = card_idx_t'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_enum_scheduler.sv
// Enumerates every 5-card board from the cards not held by either player, issues each to the evaluator, tallies verdicts.
// Latency: start -> busy +1 cycle, first eval_valid +2 cycles; then up to one board per cycle.
// Backpressure: eval_valid holds with a stable board until eval_ready; new requests stall while MAX_OUT are outstanding.
// Ports: clock/reset_n; start, hole1, hole2 (run request); busy, done, err (status);
//        eval_valid/eval_ready/eval_board (board request); res_valid/res_code (verdicts);
//        p1_wins, ties, p2_wins, total (verdict counters).
module board_enum_scheduler
    import holdem_pkg::*;
#(
    parameter int DECK    = DECK_SIZE,   // 9..63
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 4            // 1..15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DECK-1:0]  hole1,
    input  logic [DECK-1:0]  hole2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             eval_valid,
    input  logic             eval_ready,
    output logic [DECK-1:0]  eval_board,
    input  logic             res_valid,
    input  logic [1:0]       res_code,
    output logic [CNT_W-1:0] p1_wins,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] p2_wins,
    output logic [CNT_W-1:0] total
);

    localparam logic [3:0] MAX_OUT_V = 4'(MAX_OUT);

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_n_int;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n_int = rst_pipe[1];

    sched_state_e    state, state_nxt;
    logic [DECK-1:0] h1, h2, excl;
    card_idx_t       c   [BOARD_CARDS];
    card_idx_t       nc  [BOARD_CARDS];
    card_idx_t       top [BOARD_CARDS];
    logic [3:0]      outstanding, out_nxt;
    logic [DECK-1:0] board;
    logic [2:0]      sel;
    logic            has_succ, load, holes_ok, load_c;
    logic            hs, start_acc, res_ok, cnt_ok, res_bad;
    card_idx_t       from0, from1, from2, from3, from4;
    card_idx_t       nf0, nf1, nf2, nf3, nf4;
    logic            f0, f1, f2, f3, f4;

    assign excl      = h1 | h2;
    assign load      = (state == ST_CHECK);
    assign start_acc = start && (state == ST_IDLE);
    assign hs        = eval_valid && eval_ready;
    // outstanding only grows through a handshake, so once eval_valid rises it
    // cannot be pulled down by the cap before the board is taken.
    assign eval_valid = (state == ST_ISSUE) && (outstanding < MAX_OUT_V);
    assign eval_board = (state == ST_ISSUE) ? board : '0;
    assign busy       = (state == ST_CHECK) || (state == ST_ISSUE) || (state == ST_DRAIN);

    assign res_ok  = res_valid && ((state == ST_ISSUE) || (state == ST_DRAIN)) && (outstanding != '0);
    assign cnt_ok  = res_ok && (res_code_e'(res_code) != RES_BAD);
    assign res_bad = res_valid && !cnt_ok;

    assign holes_ok = ($countones(h1) == HOLE_CARDS) && ($countones(h2) == HOLE_CARDS) &&
                      ((h1 & h2) == '0) && f0 && f1 && f2 && f3 && f4;

    // top[k] is the highest value slot k can ever hold: the five highest free cards.
    always_comb begin
        int n;
        n = 0;
        for (int k = 0; k < BOARD_CARDS; k++) top[k] = '0;
        for (int i = DECK - 1; i >= 0; i--) begin
            if (!excl[i] && (n < BOARD_CARDS)) begin
                top[BOARD_CARDS - 1 - n] = card_idx_t'(i);
                n++;
            end
        end
    end

    // The slot to advance is the highest one not yet at its ceiling.
    always_comb begin
        sel      = '0;
        has_succ = 1'b0;
        for (int k = 0; k < BOARD_CARDS; k++) begin
            if (c[k] != top[k]) begin
                sel      = 3'(k);
                has_succ = 1'b1;
            end
        end
    end

    // Slot k searches above its own value when it is the advancing slot, and
    // above the freshly chosen slot k-1 when refilling. In CHECK every slot
    // refills, which yields the five lowest free cards.
    assign from0 = load ? '0 : c[0] + 6'd1;
    assign from1 = (load || sel < 3'd1) ? nf0 + 6'd1 : c[1] + 6'd1;
    assign from2 = (load || sel < 3'd2) ? nf1 + 6'd1 : c[2] + 6'd1;
    assign from3 = (load || sel < 3'd3) ? nf2 + 6'd1 : c[3] + 6'd1;
    assign from4 = (load || sel < 3'd4) ? nf3 + 6'd1 : c[4] + 6'd1;

    next_free_card #(.DECK(DECK)) u_nf0 (.excl(excl), .from_idx(from0), .idx(nf0), .found(f0));
    next_free_card #(.DECK(DECK)) u_nf1 (.excl(excl), .from_idx(from1), .idx(nf1), .found(f1));
    next_free_card #(.DECK(DECK)) u_nf2 (.excl(excl), .from_idx(from2), .idx(nf2), .found(f2));
    next_free_card #(.DECK(DECK)) u_nf3 (.excl(excl), .from_idx(from3), .idx(nf3), .found(f3));
    next_free_card #(.DECK(DECK)) u_nf4 (.excl(excl), .from_idx(from4), .idx(nf4), .found(f4));

    // Slots below the advancing one keep their value.
    always_comb begin
        nc[0] = (!load && sel > 3'd0) ? c[0] : nf0;
        nc[1] = (!load && sel > 3'd1) ? c[1] : nf1;
        nc[2] = (!load && sel > 3'd2) ? c[2] : nf2;
        nc[3] = (!load && sel > 3'd3) ? c[3] : nf3;
        nc[4] = nf4;
    end

    always_comb begin
        board = '0;
        for (int k = 0; k < BOARD_CARDS; k++) board = board | (DECK'(1) << c[k]);
    end

    always_comb begin
        out_nxt = outstanding;
        if (hs && !res_ok)      out_nxt = outstanding + 4'd1;
        else if (!hs && res_ok) out_nxt = outstanding - 4'd1;
    end

    assign load_c = (load && holes_ok) || (hs && has_succ);

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = holes_ok ? ST_ISSUE : ST_DONE;
            ST_ISSUE: if (hs && !has_succ) state_nxt = ST_DRAIN;
            // Looking at out_nxt lets done rise the cycle after the last verdict.
            ST_DRAIN: if (out_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            h1          <= '0;
            h2          <= '0;
            for (int k = 0; k < BOARD_CARDS; k++) c[k] <= '0;
            outstanding <= '0;
            p1_wins     <= '0;
            ties        <= '0;
            p2_wins     <= '0;
            total       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (start_acc) begin
                h1      <= hole1;
                h2      <= hole2;
                p1_wins <= '0;
                ties    <= '0;
                p2_wins <= '0;
                total   <= '0;
                done    <= 1'b0;
                err     <= 1'b0;
            end
            if (load_c) begin
                for (int k = 0; k < BOARD_CARDS; k++) c[k] <= nc[k];
            end
            outstanding <= out_nxt;
            if (cnt_ok) begin
                total <= total + CNT_W'(1);
                case (res_code_e'(res_code))
                    RES_P1:  p1_wins <= p1_wins + CNT_W'(1);
                    RES_TIE: ties    <= ties + CNT_W'(1);
                    RES_P2:  p2_wins <= p2_wins + CNT_W'(1);
                    default: ;
                endcase
            end
            if (res_bad || (load && !holes_ok)) err <= 1'b1;
            if (state != ST_DONE && state_nxt == ST_DONE) done <= 1'b1;
        end
    end

endmodule

// File: doc/board_enum_scheduler.md
# board_enum_scheduler

Sequencer for the two-player Texas Hold'em probability datapath. Given two players' hole cards as one-hot-per-card 52-bit masks, it enumerates every 5-card board drawn from the 48 remaining cards in lexicographic order. Each board is issued to a downstream 7-card hand evaluator over a valid/ready handshake, and the evaluator's returned verdicts are tallied into P1-win, tie and P2-win counters. It replaces the nested recursive loop structure with a single clocked FSM. Outstanding evaluator requests are bounded.

## Interface
- DECK, 52, cards in deck; bit i of a mask = card i
- CNT_W, 32, counter width; must hold C(48,5) = 1,712,304
- MAX_OUT, 4, max evaluator requests in flight (1..15)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- hole1  in  DECK  P1 hole cards; sampled on accepted start
- hole2  in  DECK  P2 hole cards; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  level; high from run completion until next accepted start
- err  out  1  invalid hole masks or result protocol violation; cleared on accepted start
- eval_valid  out  1  board request valid
- eval_ready  in  1  evaluator accepts request
- eval_board  out  DECK  5-bit-set board mask
- res_valid  in  1  one verdict returned
- res_code  in  2  00 = P1 win, 01 = tie, 10 = P2 win, 11 = ignored; sets err
- p1_wins, ties, p2_wins, total  out  CNT_W  verdict counters

## Operation
- States: IDLE, CHECK, ISSUE, DRAIN, DONE.
- IDLE -> CHECK on start. In that cycle: latch hole1/hole2, clear counters/err/done, set busy.
- CHECK (1 cycle): compute excl = hole1|hole2.
  - popcount(hole1) != 2, popcount(hole2) != 2, or hole1&hole2 != 0 -> DONE, err=1, no request ever issued.
  - Otherwise load indices c0..c4 with the five lowest free cards -> ISSUE.
- ISSUE: eval_valid=1 while outstanding < MAX_OUT. eval_board = OR of 1<<c0..c4.
  - On eval_valid&eval_ready, advance (c0<c1<c2<c3<c4, all free) to the lexicographic successor with c4 fastest.
  - The successor is found by taking the highest j whose next free index leaves enough free cards above for slots j+1..4. Set c_j to that index, refill slots j+1..4 with consecutive free cards. Computed combinationally in one cycle.
  - If no j exists, the accepted board was the last one -> DRAIN.
- DRAIN: wait for outstanding == 0 -> DONE.
- DONE: done=1, busy=0, counters hold -> IDLE (done stays high until next start).
- outstanding: +1 on handshake, -1 on res_valid; both in one cycle -> unchanged.
- Counters:
  - code 00 -> p1_wins+1; 01 -> ties+1; 10 -> p2_wins+1.
  - total increments on every res_valid with code != 11.
  - Counters wrap modulo 2^CNT_W; wrap is unreachable with the default parameters.
- res_valid with outstanding == 0, or code 11 -> err=1, no counter change, run continues.
- res_valid in IDLE/DONE -> err=1 only.
- start while not IDLE: ignored.

## Timing
- Reset (async assert, sync deassert internally):
  - State IDLE.
  - busy, done, err, eval_valid = 0.
  - eval_board and all counters = 0.
  - outstanding = 0.
- Reset mid-run: immediate abort, same values; any in-flight results after release are counted as protocol errors.
- start -> busy next cycle.
- start -> first eval_valid at cycle +2 (IDLE -> CHECK -> ISSUE).
- Max one request per cycle. With eval_ready tied high and zero-latency results: C(48,5) boards in 1,712,304 consecutive cycles.
- eval_valid, once high, stays high with eval_board stable until the handshake; no withdrawal.
- Exception: the cap on outstanding requests only suppresses eval_valid before it rises.
- Results are unordered relative to requests; only counts matter.
- done rises the cycle after the final res_valid is counted (or the cycle after CHECK on err).

## Structure
- Package holdem_pkg:
  - DECK_SIZE=52, BOARD_CARDS=5, HOLE_CARDS=2
  - NUM_BOARDS_2P=1712304
  - result-code enum {RES_P1, RES_TIE, RES_P2, RES_BAD}
  - card index typedef logic [5:0]
- One sub-module: next_free_card.
  - Combinational; returns the lowest index >= from that is not set in excl, plus a found flag.
  - Instantiated per index slot.

## Test plan
- hole1 = cards {0,1}, hole2 = {2,3}, eval_ready = 1, evaluator answers tie one cycle later. Required:
  - first eval_board = 0x1F0
  - last eval_board = bits 47..51
  - ties = total = 1,712,304, p1_wins = p2_wins = 0
  - done=1, err=0
- hole1 = {48,49}, hole2 = {50,51}: first board 0x1F, last board bits 43..47. Verdict rotation 00/01/10 gives 570,768 per counter.
- hole1 with 3 bits set, or hole1&hole2 != 0: err=1 and done=1 two cycles after start; eval_valid never asserted; counters 0.
- eval_ready held low 10 cycles mid-run: eval_board constant throughout; the full run still yields total = 1,712,304 (no skip or duplicate board, checked by a scoreboard set).
- Evaluator latency 6, MAX_OUT=4: never more than 4 requests outstanding; eval_valid drops at 4; done only after all results are returned.
- reset_n pulsed low mid-run: all outputs 0 asynchronously; a fresh start afterwards completes with correct counts. Stray res_valid while idle sets err.
